seq_alu: RTL and testbench



---
 rtl/seq_alu.sv | 143 ++++++++++++++
 tb/tb_seq_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/AND, W-cycle shift-add multiply and restoring divide.
// Define SEQ_ALU_DIV_EN to make op=3 a divide; otherwise op=3 is a bitwise AND.
module seq_alu #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   res,
  output logic [W-1:0]     rem,
  output logic             dz,
  output logic [1:0]       state_dbg
);

  // Handshake: input accepted on a rising edge where in_valid && in_ready;
  // the result is consumed on a rising edge where out_valid && out_ready.
  localparam int CW = $clog2(W + 1);
  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   acc;
  logic [W2-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [W2-1:0]   mul_next;
  logic [W:0]      sub_d;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    mul_next = acc + (mplier[0] ? mcand : '0);
    sub_d    = {1'b0, a} - {1'b0, b};
  end

`ifdef SEQ_ALU_DIV_EN
  logic          div_op;
  logic [W:0]    trial;
  logic          div_ge;
  logic [W-1:0]  div_diff;
  logic [W2-1:0] div_next;

  // acc holds {partial remainder, dividend bits still to shift in / quotient bits}.
  always_comb begin
    trial    = acc[W2-1:W-1];
    div_ge   = (trial >= {1'b0, mplier});
    div_diff = trial[W-1:0] - mplier;
    div_next = {(div_ge ? div_diff : trial[W-1:0]), acc[W-2:0], div_ge};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      res    <= '0;
      rem    <= '0;
      dz     <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_op <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= CW'(W - 1);
            acc    <= '0;
            mcand  <= W2'(a);
            mplier <= b;
            rem    <= '0;
            dz     <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_op <= (op == 2'd3);
`endif
            case (op)
              2'd0: begin
                res   <= W2'(a) + W2'(b);
                state <= DONE;
              end
              2'd1: state <= BUSY;
              2'd2: begin
                res   <= {{(W-1){sub_d[W]}}, sub_d};
                state <= DONE;
              end
              default: begin
`ifdef SEQ_ALU_DIV_EN
                if (b == '0) begin
                  res   <= W2'({W{1'b1}});
                  rem   <= a;
                  dz    <= 1'b1;
                  state <= DONE;
                end else begin
                  acc   <= W2'(a);
                  state <= BUSY;
                end
`else
                res   <= W2'(a & b);
                state <= DONE;
`endif
              end
            endcase
          end
        end
        BUSY: begin
`ifdef SEQ_ALU_DIV_EN
          if (div_op) begin
            acc <= div_next;
            if (cnt == '0) begin
              res <= W2'(div_next[W-1:0]);
              rem <= div_next[W2-1:W];
            end
          end else
`endif
          begin
            acc    <= mul_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == '0) res <= mul_next;
          end
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - CW'(1);
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (W=4): vector table through a scoreboard queue, plus reset,
// first-acceptance and stall sequences. Expects op=3 as divide when SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [1:0]     op = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*W-1:0] res;
  logic [W-1:0]   rem;
  logic           dz;
  logic [1:0]     state_dbg;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .rem(rem), .dz(dz), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // {res[7:0], rem[3:0], dz, latency[3:0]}
  logic [16:0] exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    int         hold;
    logic [16:0] expv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [16:0] pack(input int r, input int m, input int d, input int lat);
    logic [7:0] r8;
    logic [3:0] m4;
    logic [3:0] l4;
    r8 = 8'(r);
    m4 = 4'(m);
    l4 = 4'(lat);
    return {r8, m4, d[0], l4};
  endfunction

  function automatic logic [16:0] model(input int ma, input int mb, input int mop);
    case (mop)
      0: return pack(ma + mb, 0, 0, 1);
      1: return pack(ma * mb, 0, 0, W + 1);
      2: return pack(ma - mb, 0, 0, 1);
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (mb == 0) return pack(15, ma, 1, 1);
        return pack(ma / mb, ma % mb, 0, W + 1);
`else
        return pack(ma & mb, 0, 0, 1);
`endif
      end
    endcase
  endfunction

  function automatic void add_vec(input int va, input int vb, input int vop, input int hold,
                                  input logic [16:0] expv);
    vec_t v;
    v.a = 4'(va);
    v.b = 4'(vb);
    v.op = 2'(vop);
    v.hold = hold;
    v.expv = expv;
    vecs.push_back(v);
  endfunction

  task automatic junk();
    in_valid = 1'b1;
    a  = 4'($urandom_range(0, 15));
    b  = 4'($urandom_range(0, 15));
    op = 2'($urandom_range(0, 3));
  endtask

  // driver: present one transaction, wait for the result, then stall for 'hold' cycles
  task automatic run_txn(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top,
                         input int hold, input logic [16:0] expv);
    logic [16:0] e;
    int lat;
    @(negedge clk);
    chk("pre_in_ready", 32'(in_ready), 1);
    a = ta;
    b = tb;
    op = top;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 20) begin
      chk("busy_in_ready", 32'(in_ready), 0);
      junk();
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 required=1 a=%0d b=%0d op=%0d", ta, tb, top);
      in_valid = 1'b0;
      out_ready = 1'b1;
      return;
    end
    chk("res", 32'(res), 32'(e[16:9]));
    chk("rem", 32'(rem), 32'(e[8:5]));
    chk("dz", 32'(dz), 32'(e[4]));
    chk("latency", 32'(lat), 32'(e[3:0]));
    for (int h = 0; h < hold; h++) begin
      junk();
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_res", 32'(res), 32'(e[16:9]));
      chk("hold_rem", 32'(rem), 32'(e[8:5]));
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    junk();
    out_ready = 1'b1;
    @(negedge clk);
    chk("hs_out_valid", 32'(out_valid), 0);
    chk("hs_in_ready", 32'(in_ready), 1);
    in_valid = 1'b0;
  endtask

  initial begin
    // vector table: spec cases with hand-derived expectations
    add_vec(5, 3, 0, 0, pack(8, 0, 0, 1));
    add_vec(5, 3, 2, 0, pack(2, 0, 0, 1));
    add_vec(3, 5, 2, 0, pack(8'hFE, 0, 0, 1));
    add_vec(5, 3, 1, 0, pack(15, 0, 0, 5));
    add_vec(15, 15, 1, 3, pack(225, 0, 0, 5));
    add_vec(15, 15, 0, 0, pack(30, 0, 0, 1));
    add_vec(0, 15, 2, 0, pack(8'hF1, 0, 0, 1));
    add_vec(0, 15, 1, 0, pack(0, 0, 0, 5));
`ifdef SEQ_ALU_DIV_EN
    add_vec(5, 3, 3, 3, pack(1, 2, 0, 5));
    add_vec(5, 0, 3, 0, pack(8'h0F, 5, 1, 1));
    add_vec(0, 0, 3, 1, pack(8'h0F, 0, 1, 1));
    add_vec(15, 1, 3, 0, pack(15, 0, 0, 5));
`else
    add_vec(5, 3, 3, 3, pack(1, 0, 0, 1));
    add_vec(12, 10, 3, 0, pack(8, 0, 0, 1));
`endif
    for (int i = 0; i < 10; i++) begin
      int ra, rb, rop;
      ra = $urandom_range(0, 15);
      rb = $urandom_range(0, 15);
      rop = $urandom_range(0, 3);
      add_vec(ra, rb, rop, $urandom_range(0, 2), model(ra, rb, rop));
    end

    // reset state, with a transaction already presented for first-edge acceptance
    rst_n = 1'b0;
    a = 4'd5;
    b = 4'd3;
    op = 2'd0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res", 32'(res), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_dz", 32'(dz), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("first_accept_valid", 32'(out_valid), 1);
    chk("first_accept_res", 32'(res), 8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_accept_done", 32'(out_valid), 0);

    foreach (vecs[i])
      run_txn(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].hold, vecs[i].expv);

    // reset during multiply cycle 2 aborts the transaction
    run_txn(4'd15, 4'd15, 2'd1, 0, pack(225, 0, 0, 5));
    @(negedge clk);
    a = 4'd5;
    b = 4'd3;
    op = 2'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_res", 32'(res), 0);
    chk("midrst_rem", 32'(rem), 0);
    chk("midrst_dz", 32'(dz), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      chk("no_valid_after_rst", 32'(seen), 0);
    end
    run_txn(4'd5, 4'd3, 2'd0, 0, model(5, 3, 0));

    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
